// File: rtl/accel_stream_mmio.sv
// accel_stream_mmio: iomem slave that buffers a pixel stream in a FIFO and returns PACK pixels per DATA read.
// Define ACCEL_IRQ_EN to add the THR register and the level-threshold interrupt; otherwise irq is tied low.
module accel_stream_mmio #(
    parameter int PIX_W      = 8,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int MODE_W     = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              iomem_valid,
    output logic              iomem_ready,
    input  logic [3:0]        iomem_wstrb,
    input  logic [31:0]       iomem_addr,
    input  logic [31:0]       iomem_wdata,
    output logic [31:0]       iomem_rdata,
    input  logic [PIX_W-1:0]  s_pixel,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [MODE_W-1:0] mode,
    output logic              irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic              iomem_ready_q, iomem_ready_d;
    logic [31:0]       iomem_rdata_q, iomem_rdata_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              enable_q, enable_d;
    logic              underflow_q, underflow_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [PIX_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PIX_W-1:0]  mem_d [FIFO_DEPTH];

    logic        req, is_wr, is_rd, push, pop, can_pop, flush;
    logic [3:0]  addr;
    logic [31:0] stat;
    logic        unused_bits;

`ifdef ACCEL_IRQ_EN
    logic [7:0] thr_q, thr_d;
    logic       irq_q, irq_d;
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign unused_bits = ^{iomem_addr[31:4], iomem_wdata};

    assign iomem_ready = iomem_ready_q;
    assign iomem_rdata = iomem_rdata_q;
    assign mode        = mode_q;
    assign s_ready     = enable_q && (level_q < LW'(FIFO_DEPTH));

    always_comb begin
        addr    = iomem_addr[3:0];
        req     = iomem_valid && !iomem_ready_q;
        is_wr   = req && (iomem_wstrb != 4'b0);
        is_rd   = req && (iomem_wstrb == 4'b0);
        push    = s_valid && s_ready;
        can_pop = level_q >= LW'(PACK);
        pop     = is_rd && (addr == 4'h8) && can_pop;
        flush   = is_wr && (addr == 4'h0) && iomem_wdata[9];

        stat       = '0;
        stat[0]    = can_pop;
        stat[1]    = level_q == LW'(FIFO_DEPTH);
        stat[2]    = level_q == '0;
        stat[3]    = underflow_q;
        stat[15:8] = 8'(level_q);
    end

    always_comb begin
        iomem_ready_d = req;
        iomem_rdata_d = '0;
        mode_d        = mode_q;
        enable_d      = enable_q;
        underflow_d   = underflow_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        mem_d         = mem_q;
`ifdef ACCEL_IRQ_EN
        thr_d = thr_q;
        irq_d = enable_q && (thr_q != 8'd0) && (8'(level_q) >= thr_q);
`endif

        if (is_wr) begin
            case (addr)
                4'h0: begin
                    mode_d   = iomem_wdata[MODE_W-1:0];
                    enable_d = iomem_wdata[8];
                end
                4'h4: if (iomem_wdata[3]) underflow_d = 1'b0;
`ifdef ACCEL_IRQ_EN
                4'hC: thr_d = iomem_wdata[7:0];
`endif
                default: ;
            endcase
        end

        if (is_rd) begin
            case (addr)
                4'h0: begin
                    iomem_rdata_d[MODE_W-1:0] = mode_q;
                    iomem_rdata_d[8]          = enable_q;
                end
                4'h4: iomem_rdata_d = stat;
                4'h8: begin
                    if (can_pop) begin
                        for (int i = 0; i < PACK; i++)
                            iomem_rdata_d[i*PIX_W +: PIX_W] = mem_q[rd_ptr_q + AW'(i)];
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
`ifdef ACCEL_IRQ_EN
                4'hC: iomem_rdata_d[7:0] = thr_q;
`endif
                default: ;
            endcase
        end

        // Flush wins over a push on the same edge so the FIFO is guaranteed empty afterwards.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = s_pixel;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + AW'(PACK);
            level_d = level_q + LW'(push) - (pop ? LW'(PACK) : LW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            iomem_ready_q <= 1'b0;
            iomem_rdata_q <= '0;
            mode_q        <= '0;
            enable_q      <= 1'b0;
            underflow_q   <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            mem_q         <= '{default: '0};
`ifdef ACCEL_IRQ_EN
            thr_q         <= '0;
            irq_q         <= 1'b0;
`endif
        end else begin
            iomem_ready_q <= iomem_ready_d;
            iomem_rdata_q <= iomem_rdata_d;
            mode_q        <= mode_d;
            enable_q      <= enable_d;
            underflow_q   <= underflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            mem_q         <= mem_d;
`ifdef ACCEL_IRQ_EN
            thr_q         <= thr_d;
            irq_q         <= irq_d;
`endif
        end
    end

endmodule
